// File: rtl/axi_rd_sched_pkg.sv
// rtl/axi_rd_sched_pkg.sv - shared constants and helpers for the AXI read burst scheduler
package axi_rd_sched_pkg;

   // Scheduler state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CALC      = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_FINISH    = 3'd4;

   // A single AXI burst may not cross this address boundary
   localparam int BOUNDARY_BYTES = 4096;

   // Smallest of three unsigned values
   function automatic logic [31:0] min3(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] c);
      logic [31:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

endpackage

// File: rtl/axi_rd_cmd_sched_rr_arb2.sv
// rtl/axi_rd_cmd_sched_rr_arb2.sv - two-way round-robin arbiter with externally driven pointer update
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       last_owner,
   output logic       grant_id,
   output logic       grant_any
);

   logic ptr;

   // Single requester wins outright; a tie is broken by the pointer
   always_comb begin
      grant_any = |req;
      grant_id  = (req == 2'b11) ? ptr : req[1];
   end

   // After a requester finishes, the other one is favoured on the next tie
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         ptr <= 1'b0;
      else if (update)
         ptr <= ~last_owner;
   end

endmodule

// File: rtl/axi_rd_cmd_sched.sv
// rtl/axi_rd_cmd_sched.sv - two-requester burst scheduler for the AXI read engine (macro RD_SCHED_4K_SPLIT_EN enables 4 KB split)
module axi_rd_cmd_sched
   import axi_rd_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_req_valid,
   input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [2*CNT_WIDTH-1:0]  i_req_beats,
   output logic [1:0]              o_req_ready,
   output logic [1:0]              o_req_done,
   output logic                    o_cmd_valid,
   output logic [ADDR_WIDTH-1:0]   o_cmd_addr,
   output logic [7:0]              o_cmd_len,
   output logic                    o_cmd_id,
   input  logic                    i_cmd_ready,
   input  logic                    i_burst_done,
   output logic                    o_busy
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [CNT_WIDTH-1:0]  rem;
   logic [8:0]            blen;
   logic                  owner;

   logic                  grant_id;
   logic                  grant_any;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ADDR_WIDTH-1:0] sel_addr_aligned;
   logic [CNT_WIDTH-1:0]  sel_beats;
   logic [8:0]            blen_next;
   logic [ADDR_WIDTH-1:0] addr_step;

   rr_arb2 u_arb (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .req        (i_req_valid),
      .update     (state == ST_FINISH),
      .last_owner (owner),
      .grant_id   (grant_id),
      .grant_any  (grant_any)
   );

   // Request side: ready is offered only while idle, to the granted requester
   always_comb begin
      accept           = (state == ST_IDLE) && grant_any;
      o_req_ready      = accept ? {grant_id, ~grant_id} : 2'b00;
      sel_addr         = grant_id ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
      sel_beats        = grant_id ? i_req_beats[2*CNT_WIDTH-1:CNT_WIDTH] : i_req_beats[CNT_WIDTH-1:0];
      sel_addr_aligned = {sel_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
   end

`ifdef RD_SCHED_4K_SPLIT_EN
   logic [12:0] to4k;

   // Burst length limited by remaining beats, MAX_BURST and beats left in the 4 KB page
   always_comb begin
      to4k      = (13'(BOUNDARY_BYTES) - {1'b0, addr[11:0]}) >> LSB;
      blen_next = 9'(min3(32'(rem), 32'(MAX_BURST), 32'(to4k)));
   end
`else
   // Burst length limited only by remaining beats and MAX_BURST
   always_comb begin
      blen_next = 9'(min3(32'(rem), 32'(MAX_BURST), 32'(MAX_BURST)));
   end
`endif

   // Byte distance covered by the burst just completed
   always_comb begin
      addr_step = ADDR_WIDTH'(blen) << LSB;
   end

   // Main scheduler: capture request, size each burst, issue it, wait for completion
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         addr        <= '0;
         rem         <= '0;
         blen        <= '0;
         owner       <= 1'b0;
         o_req_done  <= 2'b00;
         o_cmd_valid <= 1'b0;
         o_cmd_addr  <= '0;
         o_cmd_len   <= '0;
         o_cmd_id    <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  addr   <= sel_addr_aligned;
                  rem    <= sel_beats;
                  owner  <= grant_id;
                  o_busy <= 1'b1;
                  if (sel_beats == '0) begin
                     // Nothing to fetch: report completion straight away
                     o_req_done <= {grant_id, ~grant_id};
                     state      <= ST_FINISH;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               blen        <= blen_next;
               o_cmd_valid <= 1'b1;
               o_cmd_addr  <= addr;
               o_cmd_len   <= 8'(blen_next - 9'd1);
               o_cmd_id    <= owner;
               state       <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (i_cmd_ready) begin
                  o_cmd_valid <= 1'b0;
                  state       <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (i_burst_done) begin
                  addr <= addr + addr_step;
                  rem  <= rem - CNT_WIDTH'(blen);
                  if (rem == CNT_WIDTH'(blen)) begin
                     o_req_done <= {owner, ~owner};
                     state      <= ST_FINISH;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_FINISH: begin
               o_req_done <= 2'b00;
               o_busy     <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               o_req_done  <= 2'b00;
               o_cmd_valid <= 1'b0;
               o_busy      <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_cmd_sched.sv
// tb/tb_axi_rd_cmd_sched.sv - directed scoreboard bench for axi_rd_cmd_sched
module tb_axi_rd_cmd_sched;

   localparam int AW = 32;
   localparam int CW = 16;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        id;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*CW-1:0] req_beats = '0;
   logic [1:0]    req_ready;
   logic [1:0]    req_done;
   logic          cmd_valid;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic          cmd_id;
   logic          cmd_ready = 1'b0;
   logic          burst_done = 1'b0;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done0 = 0;
   int done1 = 0;
   int vcount = 0;

   cmd_t exp_q[$];
   int   exp_done_q[$];

   axi_rd_cmd_sched #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(16), .CNT_WIDTH(16)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_addr   (req_addr),
      .i_req_beats  (req_beats),
      .o_req_ready  (req_ready),
      .o_req_done   (req_done),
      .o_cmd_valid  (cmd_valid),
      .o_cmd_addr   (cmd_addr),
      .o_cmd_len    (cmd_len),
      .o_cmd_id     (cmd_id),
      .i_cmd_ready  (cmd_ready),
      .i_burst_done (burst_done),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req_done[0]) done0 <= done0 + 1;
      if (req_done[1]) done1 <= done1 + 1;
      if (cmd_valid)   vcount <= vcount + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_cmd(input logic [31:0] a, input logic [7:0] l, input logic id);
      cmd_t e;
      e.addr = a;
      e.len  = l;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   // Present a request at a negedge, wait for ready, return the accept cycle
   task automatic request(input int n, input logic [31:0] a, input logic [15:0] b, output int t);
      int k;
      req_valid[n] = 1'b1;
      req_addr[n*AW +: AW] = a;
      req_beats[n*CW +: CW] = b;
      #1;
      k = 0;
      while (!req_ready[n] && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("req_ready", 64'(req_ready), (n == 1) ? 64'h2 : 64'h1);
      t = cyc;
      @(posedge clk);
      #1 req_valid[n] = 1'b0;
      @(negedge clk);
   endtask

   // Act as the read engine: accept every expected command, then check the done pulse
   task automatic serve(input int t_acc, input int stall);
      cmd_t e;
      int   t_ref;
      int   k;
      int   d;
      t_ref = t_acc;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         k = 0;
         while (!cmd_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("cmd_latency", 64'(cyc - t_ref), 64'd2);
         chk("busy_active", 64'(busy), 64'd1);
         for (int i = 0; i < stall; i++) begin
            chk("stall_fields", 64'({cmd_valid, cmd_addr, cmd_len, cmd_id}),
                64'({1'b1, e.addr, e.len, e.id}));
            if (i == 1) burst_done = 1'b1;
            @(posedge clk);
            #1 burst_done = 1'b0;
            @(negedge clk);
         end
         stall = 0;
         chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
         chk("cmd_len", 64'(cmd_len), 64'(e.len));
         chk("cmd_id", 64'(cmd_id), 64'(e.id));
         cmd_ready = 1'b1;
         @(posedge clk);
         #1 cmd_ready = 1'b0;
         repeat (2) @(negedge clk);
         chk("cmd_valid_drop", 64'(cmd_valid), 64'd0);
         burst_done = 1'b1;
         t_ref = cyc;
         @(posedge clk);
         #1 burst_done = 1'b0;
         @(negedge clk);
      end
      d = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : 0;
      chk("done_latency", 64'(cyc - t_ref), 64'd1);
      chk("done_pulse", 64'(req_done), (d == 1) ? 64'h2 : 64'h1);
      @(negedge clk);
      chk("done_one_cycle", 64'(req_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int t;
      int d0;
      int vc;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({req_ready, req_done, cmd_valid, cmd_addr, cmd_len, cmd_id, busy}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_outputs", 64'({req_ready, req_done, cmd_valid, cmd_addr, cmd_len, cmd_id, busy}), 64'd0);

      // Both valid after reset: req0 first, then req1, then req0 again
      req_valid[1] = 1'b1;
      req_addr[AW +: AW] = 32'h0000_300B;
      req_beats[CW +: CW] = 16'd4;
      request(0, 32'h0000_2000, 16'd4, t);
      push_cmd(32'h0000_2000, 8'd3, 1'b0);
      exp_done_q.push_back(0);
      serve(t, 0);
      request(1, 32'h0000_300B, 16'd4, t);
      push_cmd(32'h0000_3008, 8'd3, 1'b1);
      exp_done_q.push_back(1);
      serve(t, 0);
      req_valid[1] = 1'b1;
      request(0, 32'h0000_2000, 16'd4, t);
      push_cmd(32'h0000_2000, 8'd3, 1'b0);
      exp_done_q.push_back(0);
      serve(t, 0);
      request(1, 32'h0000_300B, 16'd4, t);
      push_cmd(32'h0000_3008, 8'd3, 1'b1);
      exp_done_q.push_back(1);
      serve(t, 0);

      // 40-beat request split on MAX_BURST
      request(0, 32'h0000_1000, 16'd40, t);
      push_cmd(32'h0000_1000, 8'd15, 1'b0);
      push_cmd(32'h0000_1080, 8'd15, 1'b0);
      push_cmd(32'h0000_1100, 8'd7, 1'b0);
      exp_done_q.push_back(0);
      serve(t, 0);

      // Request straddling a 4 KB boundary
      request(1, 32'h0000_0FC0, 16'd16, t);
`ifdef RD_SCHED_4K_SPLIT_EN
      push_cmd(32'h0000_0FC0, 8'd7, 1'b1);
      push_cmd(32'h0000_1000, 8'd7, 1'b1);
`else
      push_cmd(32'h0000_0FC0, 8'd15, 1'b1);
`endif
      exp_done_q.push_back(1);
      serve(t, 0);

      // Zero-beat request: done one cycle after accept, no command
      vc = vcount;
      request(0, 32'h0000_6000, 16'd0, t);
      chk("zero_done_latency", 64'(cyc - t), 64'd1);
      chk("zero_done_pulse", 64'(req_done), 64'h1);
      @(negedge clk);
      chk("zero_done_end", 64'(req_done), 64'd0);
      repeat (3) @(negedge clk);
      chk("zero_no_cmd", 64'(vcount - vc), 64'd0);

      // Stalled command with a spurious burst_done during ISSUE
      request(0, 32'h0000_4000, 16'd20, t);
      push_cmd(32'h0000_4000, 8'd15, 1'b0);
      push_cmd(32'h0000_4080, 8'd3, 1'b0);
      exp_done_q.push_back(0);
      serve(t, 5);

      // Reset during WAIT_DONE aborts the transfer without a done pulse
      request(0, 32'h0000_1000, 16'd40, t);
      begin : abort_blk
         int k;
         k = 0;
         while (!cmd_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
      end
      chk("abort_cmd_addr", 64'(cmd_addr), 64'h1000);
      cmd_ready = 1'b1;
      @(posedge clk);
      #1 cmd_ready = 1'b0;
      @(negedge clk);
      d0 = done0;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 64'({req_ready, req_done, cmd_valid, cmd_addr, cmd_len, cmd_id, busy}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_done", 64'(done0 - d0), 64'd0);
      request(0, 32'h0000_5000, 16'd8, t);
      push_cmd(32'h0000_5000, 8'd7, 1'b0);
      exp_done_q.push_back(0);
      serve(t, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
